crs_master_n: RTL and testbench
===============================

Name: crs_master_n

Overview:
- Parametrised successor of the 4-port command/response/status bus master.
- Arbitrates N peripherals onto the single system command/response bus (y) with work-conserving round-robin: idle ports are skipped and no polling cycles are spent.
- Supports single write, single read with configurable read latency, and buffered burst write drained from a per-port FIFO with an optional burst cap.
- A priority-override (po) bus can preempt the y bus at any cycle.

Parameters:
- N_PORTS, 4, number of peripherals (2..16).
- ADR_W, 12, bus address width.
- DATA_W, 16, bus data width.
- RD_LAT, 3, cycles from y_adr valid to y_rd_data sampled (1..15).
- MAX_BURST, 0, maximum buffer words per burst grant; 0 = unlimited.
- IDX_W, clog2(N_PORTS), grant index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- y_adr  out  ADR_W  bus address.
- y_wr_data  out  DATA_W  bus write data.
- y_rd_data  in  DATA_W  bus read data.
- y_wr  out  1  bus write strobe.
- po_en  in  1  priority-override enable.
- po_wr  in  1  override write strobe.
- po_adr  in  ADR_W  override address.
- po_wr_data  in  DATA_W  override write data.
- po_rd_data  out  DATA_W  override read data; equals y_rd_data combinationally.
- a_wr_req  in  N_PORTS  per-port single-write request.
- a_bwr_req  in  N_PORTS  per-port burst-write request.
- a_rd_req  in  N_PORTS  per-port read request.
- a_ack  out  N_PORTS  per-port acknowledge.
- a_adr  in  N_PORTS*ADR_W  per-port address; port k at slice k.
- a_wr_data  in  N_PORTS*DATA_W  per-port write data.
- a_rd_data  out  DATA_W  shared read-data register; valid while the granted a_ack is high.
- a_buf_rd  out  N_PORTS  per-port FIFO read pulse.
- a_buf_empty  in  N_PORTS  per-port FIFO empty.
- a_buf_data  in  N_PORTS*(ADR_W+DATA_W)  FIFO word, packed as {adr, data}; valid 1 cycle after a_buf_rd.
- grant_idx  out  IDX_W  currently granted port.
- busy  out  1  high whenever FSM is not in S_IDLE.

Behaviour:
- Reset (async): all registered outputs 0; a_rd_data=0; rr pointer=0; FSM=S_IDLE; burst count=0.
- Request of port k = a_wr_req[k] | a_bwr_req[k] | a_rd_req[k].
- Arbitration (S_IDLE, po_en low): grant the first requesting port at or after the pointer, modulo N_PORTS. Grant index is latched, and y_adr is loaded from a_adr[grant] on the same edge. Type priority within a port: wr > bwr > rd.
- Pointer update: pointer <= grant+1 (wraps N_PORTS-1 -> 0) on the ACK->IDLE transition only.
- States: S_IDLE, S_WR, S_RD_WAIT, S_BWR_CHK, S_BWR_WAIT, S_BWR_WRITE, S_ACK.
- S_WR: y_wr=1 for exactly one cycle with y_wr_data=a_wr_data[grant], then -> S_ACK.
- S_RD_WAIT: count RD_LAT cycles with y_adr held, then capture y_rd_data into a_rd_data and -> S_ACK.
- S_BWR_CHK:
  - if a_buf_empty[grant], or MAX_BURST!=0 and burst count==MAX_BURST: -> S_ACK;
  - else pulse a_buf_rd[grant] for 1 cycle and -> S_BWR_WAIT.
- S_BWR_WAIT: 1 cycle, then -> S_BWR_WRITE.
- S_BWR_WRITE: y_wr=1 for 1 cycle with {y_adr, y_wr_data}=a_buf_data[grant]; burst count+1; -> S_BWR_CHK.
- Burst count clears on entry from S_IDLE.
- S_ACK: a_ack[grant]=1; all other a_ack bits stay 0. Hold until all three request bits of the granted port are low, then drop a_ack on the same edge and -> S_IDLE.
- a_rd_data holds its last value until the next read capture.
- Latency: WR request seen at edge T -> y_wr high cycle T+1 -> a_ack high from T+2. RD -> a_ack high at T+RD_LAT+2.
- Priority override (po_en high):
  - y_adr/y_wr_data/y_wr are driven combinationally from po_*.
  - FSM freezes in its current state, including wait and burst counters.
  - No internal y_wr and no a_buf_rd are issued; no new grant is made.
  - The frozen FSM resumes exactly where it stopped on the cycle po_en falls.
  - a_ack state is unchanged during override.
- Request dropped mid-transaction: the transaction completes; a_ack pulses for 1 cycle, then -> S_IDLE.
- A new request from a just-acked port is not re-granted ahead of other requesting ports (round-robin fairness).
- An empty FIFO at burst start acks with no y_wr.
- Async reset mid-burst aborts immediately; no further a_buf_rd is issued.

Test Plan:
- Write, N=4: port2 requests write (adr 0x123, data 0xBEEF) -> one y_wr pulse at 0x123/0xBEEF at T+1; a_ack[2] high at T+2; it falls 1 cycle after the request drops; grant_idx=2.
- Read, RD_LAT=3: bus model returns 0x5A5A for adr 0x040; port0 reads -> a_rd_data=0x5A5A with a_ack[0] at T+5.
- Fairness: all 4 ports hold write requests continuously, re-raising after each ack -> grant order 0,1,2,3,0 and no port is granted twice in a row.
- Burst cap, MAX_BURST=2: port1 FIFO holds 3 words {0x010,0x1111},{0x011,0x2222},{0x012,0x3333} -> exactly 2 y_wr then ack, 1 word remains. A second bwr request drains the last word. With the FIFO empty at start -> ack with 0 y_wr.
- Override: po_en asserted for 5 cycles mid-burst with po_wr at adr 0xFFF -> bus shows only the po write. Burst resumes and total y_wr count is unchanged; po_rd_data tracks y_rd_data.
- Reset mid-read: rst pulsed asynchronously in S_RD_WAIT -> all outputs 0 immediately. The next request is served normally starting from pointer 0.

Source files
------------

// File: rtl/crs_master_n.sv
// crs_master_n -- N-port command/response/status bus master.
//
// Shares one system bus (y) among N_PORTS peripherals using work-conserving
// round-robin arbitration. It handles single writes, single reads with a
// fixed read latency, and burst writes drained from per-port FIFOs. The burst
// length can optionally be capped. A priority-override (po) bus can take the
// y bus in any cycle. While it does, the transaction FSM freezes.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   y_adr/y_wr_data/y_wr         system bus command (override-muxed)
//   y_rd_data                    system bus read data
//   po_en/po_wr/po_adr/po_wr_data  priority-override command
//   po_rd_data                   y_rd_data passed straight through
//   a_wr_req/a_bwr_req/a_rd_req  per-port request vectors
//   a_ack                        per-port acknowledge (one-hot or zero)
//   a_adr/a_wr_data              per-port packed address / write data
//   a_rd_data                    shared read-data register
//   a_buf_rd/a_buf_empty/a_buf_data  per-port burst FIFO interface
//   grant_idx, busy              current grant and FSM-active flag
module crs_master_n #(
  parameter int N_PORTS   = 4,
  parameter int ADR_W     = 12,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 3,
  parameter int MAX_BURST = 0,
  parameter int IDX_W     = $clog2(N_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [ADR_W-1:0]                  y_adr,
  output logic [DATA_W-1:0]                 y_wr_data,
  input  logic [DATA_W-1:0]                 y_rd_data,
  output logic                              y_wr,
  input  logic                              po_en,
  input  logic                              po_wr,
  input  logic [ADR_W-1:0]                  po_adr,
  input  logic [DATA_W-1:0]                 po_wr_data,
  output logic [DATA_W-1:0]                 po_rd_data,
  input  logic [N_PORTS-1:0]                a_wr_req,
  input  logic [N_PORTS-1:0]                a_bwr_req,
  input  logic [N_PORTS-1:0]                a_rd_req,
  output logic [N_PORTS-1:0]                a_ack,
  input  logic [N_PORTS*ADR_W-1:0]          a_adr,
  input  logic [N_PORTS*DATA_W-1:0]         a_wr_data,
  output logic [DATA_W-1:0]                 a_rd_data,
  output logic [N_PORTS-1:0]                a_buf_rd,
  input  logic [N_PORTS-1:0]                a_buf_empty,
  input  logic [N_PORTS*(ADR_W+DATA_W)-1:0] a_buf_data,
  output logic [IDX_W-1:0]                  grant_idx,
  output logic                              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_WAIT, S_BWR_CHK, S_BWR_WAIT, S_BWR_WRITE, S_ACK
  } state_t;

  localparam int                 CNT_W     = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CNT_W-1:0]   BURST_CAP = CNT_W'(MAX_BURST);
  localparam logic [3:0]         RD_LAST   = 4'(RD_LAT);
  localparam logic [IDX_W-1:0]   LAST_PORT = IDX_W'(N_PORTS - 1);
  localparam logic [N_PORTS-1:0] ONE_HOT0  = N_PORTS'(1);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         grant_q, ptr_q;
  logic [ADR_W-1:0]         y_adr_q;
  logic [DATA_W-1:0]        y_wr_data_q;
  logic [DATA_W-1:0]        a_rd_data_q;
  logic [3:0]               wait_cnt_q;
  logic [CNT_W-1:0]         burst_cnt_q;

  logic [ADR_W-1:0]         adr_v  [N_PORTS];
  logic [DATA_W-1:0]        wdat_v [N_PORTS];
  logic [ADR_W+DATA_W-1:0]  buf_v  [N_PORTS];
  logic [N_PORTS-1:0]       req;
  logic [N_PORTS-1:0]       grant_oh;
  logic [IDX_W-1:0]         pick, cand;
  logic                     pick_valid;
  logic                     burst_stop;
  logic                     int_wr;

  // Unpack the flat per-port buses into arrays that are indexed by port.
  for (genvar k = 0; k < N_PORTS; k++) begin : g_unpack
    assign adr_v[k]  = a_adr[k*ADR_W +: ADR_W];
    assign wdat_v[k] = a_wr_data[k*DATA_W +: DATA_W];
    assign buf_v[k]  = a_buf_data[k*(ADR_W+DATA_W) +: (ADR_W+DATA_W)];
  end

  assign req      = a_wr_req | a_bwr_req | a_rd_req;
  assign grant_oh = ONE_HOT0 << grant_q;

  // Work-conserving round-robin. Scan from the pointer and take the first
  // requester. Idle ports cost no cycles.
  // NOTE: every variable written in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % N_PORTS);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  assign burst_stop = a_buf_empty[grant_q] ||
                      ((MAX_BURST != 0) && (burst_cnt_q == BURST_CAP));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          if (a_wr_req[pick])       state_d = S_WR;
          else if (a_bwr_req[pick]) state_d = S_BWR_CHK;
          else                      state_d = S_RD_WAIT;
        end
      end
      S_WR:        state_d = S_ACK;
      S_RD_WAIT:   if (wait_cnt_q == RD_LAST) state_d = S_ACK;
      S_BWR_CHK:   state_d = burst_stop ? S_ACK : S_BWR_WAIT;
      S_BWR_WAIT:  state_d = S_BWR_WRITE;
      S_BWR_WRITE: state_d = S_BWR_CHK;
      S_ACK:       if (!req[grant_q]) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    // Override freezes the FSM where it is.
    if (po_en) state_d = state_q;
  end

  // NOTE: all sequential state uses non-blocking assignments. Every register
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      y_adr_q     <= '0;
      y_wr_data_q <= '0;
      a_rd_data_q <= '0;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else if (!po_en) begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            grant_q     <= pick;
            y_adr_q     <= adr_v[pick];
            y_wr_data_q <= wdat_v[pick];
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
          end
        end
        // The address is launched at the grant edge. The wait spans RD_LAT
        // cycles beyond the first one on the bus, and the capture lands on
        // the edge that follows.
        S_RD_WAIT: begin
          if (wait_cnt_q == RD_LAST) a_rd_data_q <= y_rd_data;
          else                       wait_cnt_q  <= wait_cnt_q + 1'b1;
        end
        // The FIFO word is valid one cycle after a_buf_rd. Register it here so
        // that the write cycle drives stable values.
        S_BWR_WAIT:  {y_adr_q, y_wr_data_q} <= buf_v[grant_q];
        S_BWR_WRITE: burst_cnt_q <= burst_cnt_q + 1'b1;
        S_ACK: begin
          if (state_d == S_IDLE)
            ptr_q <= (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign int_wr     = (state_q == S_WR) || (state_q == S_BWR_WRITE);
  assign y_wr       = po_en ? po_wr      : int_wr;
  assign y_adr      = po_en ? po_adr     : y_adr_q;
  assign y_wr_data  = po_en ? po_wr_data : y_wr_data_q;
  assign po_rd_data = y_rd_data;

  assign a_buf_rd   = (!po_en && state_q == S_BWR_CHK && !burst_stop) ? grant_oh : '0;
  assign a_ack      = (state_q == S_ACK) ? grant_oh : '0;
  assign a_rd_data  = a_rd_data_q;
  assign grant_idx  = grant_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_crs_master_n.sv
// Directed testbench for crs_master_n (N_PORTS=4, RD_LAT=3, MAX_BURST=2).
// A combinational bus memory model drives y_rd_data. Port 1 owns a small
// FIFO model. Every bus write is logged at the falling edge.
`timescale 1ns/1ps
module tb_crs_master_n;

  localparam int N = 4;
  localparam int AW = 12;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [AW-1:0]     y_adr;
  logic [DW-1:0]     y_wr_data;
  logic [DW-1:0]     y_rd_data;
  logic              y_wr;
  logic              po_en = 1'b0;
  logic              po_wr = 1'b0;
  logic [AW-1:0]     po_adr = '0;
  logic [DW-1:0]     po_wr_data = '0;
  logic [DW-1:0]     po_rd_data;
  logic [N-1:0]      a_wr_req = '0;
  logic [N-1:0]      a_bwr_req = '0;
  logic [N-1:0]      a_rd_req = '0;
  logic [N-1:0]      a_ack;
  logic [N*AW-1:0]   a_adr = '0;
  logic [N*DW-1:0]   a_wr_data = '0;
  logic [DW-1:0]     a_rd_data;
  logic [N-1:0]      a_buf_rd;
  logic [N-1:0]      a_buf_empty;
  logic [N*(AW+DW)-1:0] a_buf_data;
  logic [1:0]        grant_idx;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Port-1 FIFO model: entries are written by the stimulus and popped on a_buf_rd.
  logic [AW+DW-1:0] fifo_mem [8];
  int               fifo_len = 0;
  int               rd_ptr = 0;
  logic [AW+DW-1:0] buf_word = '0;
  logic [AW+DW-1:0] wlog [$];

  always #5 clk = ~clk;

  assign y_rd_data   = (y_adr == 12'h040) ? 16'h5A5A : ({4'h0, y_adr} ^ 16'h1234);
  assign a_buf_empty = {2'b11, (rd_ptr == fifo_len), 1'b1};
  assign a_buf_data  = {28'h0, 28'h0, buf_word, 28'h0};

  always @(posedge clk) begin
    if (a_buf_rd[1]) begin
      buf_word <= fifo_mem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (y_wr === 1'b1) wlog.push_back({y_adr, y_wr_data});
  end

  crs_master_n #(
    .N_PORTS(N), .ADR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_BURST(2)
  ) dut (
    .clk(clk), .rst(rst),
    .y_adr(y_adr), .y_wr_data(y_wr_data), .y_rd_data(y_rd_data), .y_wr(y_wr),
    .po_en(po_en), .po_wr(po_wr), .po_adr(po_adr), .po_wr_data(po_wr_data),
    .po_rd_data(po_rd_data),
    .a_wr_req(a_wr_req), .a_bwr_req(a_bwr_req), .a_rd_req(a_rd_req), .a_ack(a_ack),
    .a_adr(a_adr), .a_wr_data(a_wr_data), .a_rd_data(a_rd_data),
    .a_buf_rd(a_buf_rd), .a_buf_empty(a_buf_empty), .a_buf_data(a_buf_data),
    .grant_idx(grant_idx), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int n = 0;
    while (a_ack == '0 && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(a_ack != '0), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    int gi;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    // Reset state.
    #1 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ack", a_ack, 0);
    check("rst_y_wr", y_wr, 0);
    check("rst_y_adr", y_adr, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_rd_data", a_rd_data, 0);
    #20 rst = 1'b0;
    tick(1);

    // Fairness: all ports keep write requests up and re-raise after each ack.
    for (int k = 0; k < N; k++) begin
      a_adr[k*AW +: AW]     = 12'(12'h200 + k);
      a_wr_data[k*DW +: DW] = 16'(16'h1000 + k);
    end
    a_wr_req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_ack("fair_ack_timeout", 40);
      check("fair_grant", grant_idx, exp_order[g]);
      check("fair_ack", a_ack, 4'b0001 << exp_order[g]);
      gi = int'(grant_idx);
      a_wr_req[gi] = 1'b0;
      tick(1);
      a_wr_req[gi] = 1'b1;
    end
    a_wr_req = '0;
    tick(2);
    check("fair_idle", busy, 0);

    // Single write on port 2.
    a_adr[2*AW +: AW]     = 12'h123;
    a_wr_data[2*DW +: DW] = 16'hBEEF;
    base = wlog.size();
    a_wr_req = 4'b0100;
    tick(1);
    check("wr_y_wr", y_wr, 1);
    check("wr_y_adr", y_adr, 12'h123);
    check("wr_y_data", y_wr_data, 16'hBEEF);
    check("wr_grant", grant_idx, 2);
    check("wr_no_early_ack", a_ack, 0);
    tick(1);
    check("wr_ack", a_ack, 4'b0100);
    check("wr_y_wr_once", y_wr, 0);
    tick(1);
    check("wr_ack_hold", a_ack, 4'b0100);
    a_wr_req = '0;
    tick(1);
    check("wr_ack_drop", a_ack, 0);
    check("wr_count", wlog.size() - base, 1);
    check("wr_log", wlog[base], 28'h123BEEF);

    // Request dropped mid-transaction: ack pulses for one cycle.
    a_wr_req = 4'b0100;
    tick(1);
    a_wr_req = '0;
    tick(1);
    check("drop_ack_pulse", a_ack, 4'b0100);
    tick(1);
    check("drop_ack_gone", a_ack, 0);

    // Read on port 0 with RD_LAT=3: ack 5 cycles after the grant edge.
    a_adr[0*AW +: AW] = 12'h040;
    a_rd_req = 4'b0001;
    tick(1);
    check("rd_grant", grant_idx, 0);
    check("rd_y_adr", y_adr, 12'h040);
    tick(3);
    check("rd_no_early_ack", a_ack, 0);
    tick(1);
    check("rd_ack", a_ack, 4'b0001);
    check("rd_data", a_rd_data, 16'h5A5A);
    check("po_rd_track", po_rd_data, 16'h5A5A);
    a_rd_req = '0;
    tick(1);
    check("rd_ack_drop", a_ack, 0);
    check("rd_data_hold", a_rd_data, 16'h5A5A);

    // Burst on port 1 with 3 words and a cap of 2.
    fifo_mem[0] = 28'h0101111;
    fifo_mem[1] = 28'h0112222;
    fifo_mem[2] = 28'h0123333;
    fifo_len = 3;
    a_adr[1*AW +: AW] = 12'h300;
    base = wlog.size();
    a_bwr_req = 4'b0010;
    wait_ack("bwr1_ack_timeout", 40);
    check("bwr1_count", wlog.size() - base, 2);
    check("bwr1_w0", wlog[base], 28'h0101111);
    check("bwr1_w1", wlog[base + 1], 28'h0112222);
    check("bwr1_left", rd_ptr, 2);
    a_bwr_req = '0;
    tick(1);
    check("bwr1_ack_drop", a_ack, 0);

    base = wlog.size();
    a_bwr_req = 4'b0010;
    wait_ack("bwr2_ack_timeout", 40);
    check("bwr2_count", wlog.size() - base, 1);
    check("bwr2_w2", wlog[base], 28'h0123333);
    check("bwr2_drained", rd_ptr, 3);
    a_bwr_req = '0;
    tick(1);

    base = wlog.size();
    a_bwr_req = 4'b0010;
    wait_ack("bwr_empty_ack_timeout", 40);
    check("bwr_empty_count", wlog.size() - base, 0);
    check("bwr_empty_no_rd", rd_ptr, 3);
    a_bwr_req = '0;
    tick(1);

    // Override for 5 cycles while the burst waits for FIFO data.
    fifo_mem[3] = 28'h020AAAA;
    fifo_mem[4] = 28'h021BBBB;
    fifo_len = 5;
    base = wlog.size();
    a_bwr_req = 4'b0010;
    tick(2);
    po_en = 1'b1;
    po_wr = 1'b1;
    po_adr = 12'hFFF;
    po_wr_data = 16'hC0DE;
    #1;
    check("po_y_adr", y_adr, 12'hFFF);
    check("po_y_wr", y_wr, 1);
    check("po_y_data", y_wr_data, 16'hC0DE);
    check("po_rd_data", po_rd_data, 16'h1DCB);
    tick(1);
    po_wr = 1'b0;
    #1;
    check("po_quiet_wr", y_wr, 0);
    check("po_no_buf_rd", a_buf_rd, 0);
    check("po_grant_kept", grant_idx, 1);
    check("po_ack_kept", a_ack, 0);
    tick(4);
    po_en = 1'b0;
    #1;
    check("po_frozen_adr", y_adr, 12'h300);
    wait_ack("po_ack_timeout", 40);
    check("po_total_wr", wlog.size() - base, 3);
    check("po_log0", wlog[base], 28'hFFFC0DE);
    check("po_log1", wlog[base + 1], 28'h020AAAA);
    check("po_log2", wlog[base + 2], 28'h021BBBB);
    check("po_fifo_pops", rd_ptr, 5);
    a_bwr_req = '0;
    tick(1);

    // Reset in S_RD_WAIT, then arbitration restarts from pointer 0.
    a_adr[3*AW +: AW] = 12'h055;
    a_rd_req = 4'b1000;
    tick(1);
    check("rrst_grant3", grant_idx, 3);
    tick(1);
    #2 rst = 1'b1;
    #1;
    check("rrst_busy", busy, 0);
    check("rrst_grant", grant_idx, 0);
    check("rrst_y_adr", y_adr, 0);
    check("rrst_rd_data", a_rd_data, 0);
    check("rrst_ack", a_ack, 0);
    #1 rst = 1'b0;
    a_rd_req = 4'b1001;
    tick(1);
    check("rrst_ptr0", grant_idx, 0);
    wait_ack("rrst_ack_timeout", 40);
    check("rrst_ack0", a_ack, 4'b0001);
    check("rrst_data", a_rd_data, 16'h5A5A);
    a_rd_req = '0;
    tick(2);
    check("rrst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
